// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers dispatched ops, snoops ALU/LSB CDBs, issues the lowest ready entry per cycle.
// Optional performance counters enabled by defining RS_PERF_CNT_EN.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int ROB_BITS = 4,
    parameter int OP_BITS  = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                in_dispatch_enable,
    input  logic [OP_BITS-1:0]  in_dispatch_type,
    input  logic [31:0]         in_dispatch_pc,
    input  logic [31:0]         in_dispatch_imm,
    input  logic [ROB_BITS-1:0] in_dispatch_reorder,
    input  logic                in_dispatch_rs_ready,
    input  logic                in_dispatch_rt_ready,
    input  logic [31:0]         in_dispatch_rs_value,
    input  logic [31:0]         in_dispatch_rt_value,
    input  logic [ROB_BITS-1:0] in_dispatch_rs_reorder,
    input  logic [ROB_BITS-1:0] in_dispatch_rt_reorder,
    input  logic                in_alu_cdb_enable,
    input  logic [ROB_BITS-1:0] in_alu_cdb_reorder,
    input  logic [31:0]         in_alu_cdb_result,
    input  logic                in_lsb_cdb_enable,
    input  logic [ROB_BITS-1:0] in_lsb_cdb_reorder,
    input  logic [31:0]         in_lsb_cdb_result,
    output logic                out_full,
    output logic                out_alu_enable,
    output logic [OP_BITS-1:0]  out_alu_type,
    output logic [31:0]         out_alu_pc,
    output logic [31:0]         out_alu_imm,
    output logic [31:0]         out_alu_rs,
    output logic [31:0]         out_alu_rt,
    output logic [ROB_BITS-1:0] out_alu_reorder
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0]         out_perf_issue_cnt,
    output logic [31:0]         out_perf_full_cnt
`endif
);
    localparam int IDX = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  busy_reg;
    logic [RS_SIZE-1:0]  rs_ready_reg;
    logic [RS_SIZE-1:0]  rt_ready_reg;
    logic [OP_BITS-1:0]  type_reg     [RS_SIZE];
    logic [31:0]         pc_reg       [RS_SIZE];
    logic [31:0]         imm_reg      [RS_SIZE];
    logic [ROB_BITS-1:0] dest_reg     [RS_SIZE];
    logic [31:0]         rs_value_reg [RS_SIZE];
    logic [31:0]         rt_value_reg [RS_SIZE];
    logic [ROB_BITS-1:0] rs_tag_reg   [RS_SIZE];
    logic [ROB_BITS-1:0] rt_tag_reg   [RS_SIZE];

    logic [RS_SIZE-1:0] cand;
    logic [RS_SIZE-1:0] rs_alu_hit, rs_lsb_hit, rt_alu_hit, rt_lsb_hit;
    logic [IDX-1:0]     free_idx, sel_idx;
    logic               sel_found;
    logic               do_dispatch, do_issue;
    logic               disp_rs_ready, disp_rt_ready;
    logic [31:0]        disp_rs_value, disp_rt_value;

    assign cand        = busy_reg & rs_ready_reg & rt_ready_reg;
    assign out_full    = &busy_reg;
    assign do_dispatch = rdy_in && !clear_in && in_dispatch_enable && !out_full;
    assign do_issue    = rdy_in && !clear_in && sel_found;

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_hit
            assign rs_alu_hit[gi] = in_alu_cdb_enable && (in_alu_cdb_reorder == rs_tag_reg[gi]);
            assign rs_lsb_hit[gi] = in_lsb_cdb_enable && (in_lsb_cdb_reorder == rs_tag_reg[gi]);
            assign rt_alu_hit[gi] = in_alu_cdb_enable && (in_alu_cdb_reorder == rt_tag_reg[gi]);
            assign rt_lsb_hit[gi] = in_lsb_cdb_enable && (in_lsb_cdb_reorder == rt_tag_reg[gi]);
        end
    endgenerate

    // Lowest-index free slot and lowest-index ready candidate, both from pre-edge state.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDX'(i);
            if (cand[i]) begin
                sel_idx   = IDX'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Same-cycle CDB bypass so a broadcast racing the ROB lookup is not lost.
    always_comb begin
        disp_rs_ready = in_dispatch_rs_ready;
        disp_rs_value = in_dispatch_rs_value;
        disp_rt_ready = in_dispatch_rt_ready;
        disp_rt_value = in_dispatch_rt_value;
        if (!in_dispatch_rs_ready) begin
            if (in_alu_cdb_enable && in_alu_cdb_reorder == in_dispatch_rs_reorder) begin
                disp_rs_ready = 1'b1;
                disp_rs_value = in_alu_cdb_result;
            end else if (in_lsb_cdb_enable && in_lsb_cdb_reorder == in_dispatch_rs_reorder) begin
                disp_rs_ready = 1'b1;
                disp_rs_value = in_lsb_cdb_result;
            end
        end
        if (!in_dispatch_rt_ready) begin
            if (in_alu_cdb_enable && in_alu_cdb_reorder == in_dispatch_rt_reorder) begin
                disp_rt_ready = 1'b1;
                disp_rt_value = in_alu_cdb_result;
            end else if (in_lsb_cdb_enable && in_lsb_cdb_reorder == in_dispatch_rt_reorder) begin
                disp_rt_ready = 1'b1;
                disp_rt_value = in_lsb_cdb_result;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_in) begin
            busy_reg <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (do_dispatch && free_idx == IDX'(i)) begin
                    busy_reg[i]     <= 1'b1;
                    type_reg[i]     <= in_dispatch_type;
                    pc_reg[i]       <= in_dispatch_pc;
                    imm_reg[i]      <= in_dispatch_imm;
                    dest_reg[i]     <= in_dispatch_reorder;
                    rs_ready_reg[i] <= disp_rs_ready;
                    rs_value_reg[i] <= disp_rs_value;
                    rs_tag_reg[i]   <= in_dispatch_rs_reorder;
                    rt_ready_reg[i] <= disp_rt_ready;
                    rt_value_reg[i] <= disp_rt_value;
                    rt_tag_reg[i]   <= in_dispatch_rt_reorder;
                end else begin
                    if (do_issue && sel_idx == IDX'(i)) busy_reg[i] <= 1'b0;
                    if (busy_reg[i] && !rs_ready_reg[i] && (rs_alu_hit[i] || rs_lsb_hit[i])) begin
                        rs_ready_reg[i] <= 1'b1;
                        rs_value_reg[i] <= rs_alu_hit[i] ? in_alu_cdb_result : in_lsb_cdb_result;
                    end
                    if (busy_reg[i] && !rt_ready_reg[i] && (rt_alu_hit[i] || rt_lsb_hit[i])) begin
                        rt_ready_reg[i] <= 1'b1;
                        rt_value_reg[i] <= rt_alu_hit[i] ? in_alu_cdb_result : in_lsb_cdb_result;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            out_alu_enable  <= 1'b0;
            out_alu_type    <= '0;
            out_alu_pc      <= '0;
            out_alu_imm     <= '0;
            out_alu_rs      <= '0;
            out_alu_rt      <= '0;
            out_alu_reorder <= '0;
        end else if (do_issue) begin
            out_alu_enable  <= 1'b1;
            out_alu_type    <= type_reg[sel_idx];
            out_alu_pc      <= pc_reg[sel_idx];
            out_alu_imm     <= imm_reg[sel_idx];
            out_alu_rs      <= rs_value_reg[sel_idx];
            out_alu_rt      <= rt_value_reg[sel_idx];
            out_alu_reorder <= dest_reg[sel_idx];
        end else begin
            out_alu_enable  <= 1'b0;
        end
    end

`ifdef RS_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            out_perf_issue_cnt <= '0;
            out_perf_full_cnt  <= '0;
        end else begin
            if (do_issue) out_perf_issue_cnt <= out_perf_issue_cnt + 32'd1;
            if (out_full && rdy_in) out_perf_full_cnt <= out_perf_full_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: dispatch/bypass vector table plus wakeup, fill, flush, stall and reset sequences.
// An issue scoreboard compares every out_alu_enable cycle against the expected op queue.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        in_dispatch_enable;
    logic [5:0]  in_dispatch_type;
    logic [31:0] in_dispatch_pc, in_dispatch_imm;
    logic [3:0]  in_dispatch_reorder;
    logic        in_dispatch_rs_ready, in_dispatch_rt_ready;
    logic [31:0] in_dispatch_rs_value, in_dispatch_rt_value;
    logic [3:0]  in_dispatch_rs_reorder, in_dispatch_rt_reorder;
    logic        in_alu_cdb_enable, in_lsb_cdb_enable;
    logic [3:0]  in_alu_cdb_reorder, in_lsb_cdb_reorder;
    logic [31:0] in_alu_cdb_result, in_lsb_cdb_result;
    logic        out_full, out_alu_enable;
    logic [5:0]  out_alu_type;
    logic [31:0] out_alu_pc, out_alu_imm, out_alu_rs, out_alu_rt;
    logic [3:0]  out_alu_reorder;
`ifdef RS_PERF_CNT_EN
    logic [31:0] out_perf_issue_cnt, out_perf_full_cnt;
`endif

    reservation_station #(.RS_SIZE(16), .ROB_BITS(4), .OP_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_dispatch_enable(in_dispatch_enable), .in_dispatch_type(in_dispatch_type),
        .in_dispatch_pc(in_dispatch_pc), .in_dispatch_imm(in_dispatch_imm),
        .in_dispatch_reorder(in_dispatch_reorder),
        .in_dispatch_rs_ready(in_dispatch_rs_ready), .in_dispatch_rt_ready(in_dispatch_rt_ready),
        .in_dispatch_rs_value(in_dispatch_rs_value), .in_dispatch_rt_value(in_dispatch_rt_value),
        .in_dispatch_rs_reorder(in_dispatch_rs_reorder), .in_dispatch_rt_reorder(in_dispatch_rt_reorder),
        .in_alu_cdb_enable(in_alu_cdb_enable), .in_alu_cdb_reorder(in_alu_cdb_reorder),
        .in_alu_cdb_result(in_alu_cdb_result),
        .in_lsb_cdb_enable(in_lsb_cdb_enable), .in_lsb_cdb_reorder(in_lsb_cdb_reorder),
        .in_lsb_cdb_result(in_lsb_cdb_result),
        .out_full(out_full), .out_alu_enable(out_alu_enable), .out_alu_type(out_alu_type),
        .out_alu_pc(out_alu_pc), .out_alu_imm(out_alu_imm), .out_alu_rs(out_alu_rs),
        .out_alu_rt(out_alu_rt), .out_alu_reorder(out_alu_reorder)
`ifdef RS_PERF_CNT_EN
        , .out_perf_issue_cnt(out_perf_issue_cnt), .out_perf_full_cnt(out_perf_full_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  typ;
        logic [31:0] pc, imm, rs, rt;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [5:0]  typ;
        logic [31:0] pc, imm;
        logic [3:0]  tag;
        logic        rs_rdy;  logic [31:0] rs_val;  logic [3:0] rs_tag;
        logic        rt_rdy;  logic [31:0] rt_val;  logic [3:0] rt_tag;
        logic        alu_en;  logic [3:0]  alu_tag; logic [31:0] alu_val;
        logic        lsb_en;  logic [3:0]  lsb_tag; logic [31:0] lsb_val;
        logic [31:0] exp_rs, exp_rt;
    } vec_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs;
        in_dispatch_enable = 1'b0;
        in_alu_cdb_enable  = 1'b0;
        in_lsb_cdb_enable  = 1'b0;
        clear_in           = 1'b0;
    endtask

    task automatic drive_dispatch(input logic [5:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [3:0] tag,
                                  input logic rs_rdy, input logic [31:0] rs_val, input logic [3:0] rs_tag,
                                  input logic rt_rdy, input logic [31:0] rt_val, input logic [3:0] rt_tag);
        in_dispatch_enable     = 1'b1;
        in_dispatch_type       = typ;
        in_dispatch_pc         = pc;
        in_dispatch_imm        = imm;
        in_dispatch_reorder    = tag;
        in_dispatch_rs_ready   = rs_rdy;
        in_dispatch_rs_value   = rs_val;
        in_dispatch_rs_reorder = rs_tag;
        in_dispatch_rt_ready   = rt_rdy;
        in_dispatch_rt_value   = rt_val;
        in_dispatch_rt_reorder = rt_tag;
    endtask

    task automatic drive_alu(input logic [3:0] tag, input logic [31:0] val);
        in_alu_cdb_enable  = 1'b1;
        in_alu_cdb_reorder = tag;
        in_alu_cdb_result  = val;
    endtask

    task automatic drive_lsb(input logic [3:0] tag, input logic [31:0] val);
        in_lsb_cdb_enable  = 1'b1;
        in_lsb_cdb_reorder = tag;
        in_lsb_cdb_result  = val;
    endtask

    // Issue monitor: every enabled ALU cycle must match the oldest expected op.
    always @(negedge clk_in) begin
        if (out_alu_enable) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_issue: got issue tag %0d rs %h expected no issue", out_alu_reorder, out_alu_rs);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("issue tag=%0d type=%h pc=%h imm=%h rs=%h rt=%h", out_alu_reorder, out_alu_type,
                         out_alu_pc, out_alu_imm, out_alu_rs, out_alu_rt);
                check("issue_reorder", 32'(out_alu_reorder), 32'(e.tag));
                check("issue_type", 32'(out_alu_type), 32'(e.typ));
                check("issue_pc", out_alu_pc, e.pc);
                check("issue_imm", out_alu_imm, e.imm);
                check("issue_rs", out_alu_rs, e.rs);
                check("issue_rt", out_alu_rt, e.rt);
            end
        end
    end

    vec_t vec[5];

    initial begin
        vec[0] = '{typ:6'h01, pc:32'h1000, imm:32'h0, tag:4'd3,
                   rs_rdy:1'b1, rs_val:32'd5, rs_tag:4'd0, rt_rdy:1'b1, rt_val:32'd7, rt_tag:4'd0,
                   alu_en:1'b0, alu_tag:4'd0, alu_val:32'h0, lsb_en:1'b0, lsb_tag:4'd0, lsb_val:32'h0,
                   exp_rs:32'd5, exp_rt:32'd7};
        vec[1] = '{typ:6'h02, pc:32'h1004, imm:32'h4, tag:4'd4,
                   rs_rdy:1'b1, rs_val:32'h11, rs_tag:4'd0, rt_rdy:1'b0, rt_val:32'h0, rt_tag:4'd6,
                   alu_en:1'b0, alu_tag:4'd0, alu_val:32'h0, lsb_en:1'b1, lsb_tag:4'd6, lsb_val:32'hABCD,
                   exp_rs:32'h11, exp_rt:32'hABCD};
        vec[2] = '{typ:6'h05, pc:32'h1008, imm:32'h8, tag:4'd8,
                   rs_rdy:1'b0, rs_val:32'h0, rs_tag:4'd9, rt_rdy:1'b1, rt_val:32'h22, rt_tag:4'd0,
                   alu_en:1'b1, alu_tag:4'd9, alu_val:32'hDEADBEEF, lsb_en:1'b0, lsb_tag:4'd0, lsb_val:32'h0,
                   exp_rs:32'hDEADBEEF, exp_rt:32'h22};
        vec[3] = '{typ:6'h07, pc:32'h100C, imm:32'hC, tag:4'd15,
                   rs_rdy:1'b0, rs_val:32'h0, rs_tag:4'd10, rt_rdy:1'b0, rt_val:32'h0, rt_tag:4'd11,
                   alu_en:1'b1, alu_tag:4'd10, alu_val:32'h1234, lsb_en:1'b1, lsb_tag:4'd11, lsb_val:32'h5678,
                   exp_rs:32'h1234, exp_rt:32'h5678};
        vec[4] = '{typ:6'h09, pc:32'h1010, imm:32'h10, tag:4'd1,
                   rs_rdy:1'b1, rs_val:32'h33, rs_tag:4'd2, rt_rdy:1'b1, rt_val:32'h44, rt_tag:4'd2,
                   alu_en:1'b1, alu_tag:4'd2, alu_val:32'h999, lsb_en:1'b1, lsb_tag:4'd2, lsb_val:32'h888,
                   exp_rs:32'h33, exp_rt:32'h44};

        rst_in = 1'b0; rdy_in = 1'b1;
        idle_inputs();
        drive_dispatch(6'h0, 32'h0, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
        in_dispatch_enable = 1'b0;
        in_alu_cdb_reorder = 4'd0; in_alu_cdb_result = 32'h0;
        in_lsb_cdb_reorder = 4'd0; in_lsb_cdb_result = 32'h0;
        tick(); tick();
        rst_in = 1'b1;
        check("reset_full", 32'(out_full), 32'd0);
        check("reset_enable", 32'(out_alu_enable), 32'd0);
        check("reset_rs", out_alu_rs, 32'd0);
        check("reset_reorder", 32'(out_alu_reorder), 32'd0);

        // Table: single op dispatched ready or via same-cycle bypass issues exactly one cycle later.
        for (int i = 0; i < 5; i++) begin
            drive_dispatch(vec[i].typ, vec[i].pc, vec[i].imm, vec[i].tag,
                           vec[i].rs_rdy, vec[i].rs_val, vec[i].rs_tag,
                           vec[i].rt_rdy, vec[i].rt_val, vec[i].rt_tag);
            if (vec[i].alu_en) drive_alu(vec[i].alu_tag, vec[i].alu_val);
            if (vec[i].lsb_en) drive_lsb(vec[i].lsb_tag, vec[i].lsb_val);
            sb.push_back('{typ:vec[i].typ, pc:vec[i].pc, imm:vec[i].imm,
                           rs:vec[i].exp_rs, rt:vec[i].exp_rt, tag:vec[i].tag});
            tick();
            idle_inputs();
            check("vec_wait_enable", 32'(out_alu_enable), 32'd0);
            tick();
            check("vec_issue_enable", 32'(out_alu_enable), 32'd1);
            tick();
            check("vec_after_enable", 32'(out_alu_enable), 32'd0);
        end

        // Wakeup: rs waits on tag 2; unrelated LSB broadcast must not wake it.
        drive_dispatch(6'h0A, 32'h3000, 32'h0, 4'd12, 1'b0, 32'h0, 4'd2, 1'b1, 32'h9, 4'd0);
        sb.push_back('{typ:6'h0A, pc:32'h3000, imm:32'h0, rs:32'h10, rt:32'h9, tag:4'd12});
        tick();
        idle_inputs();
        drive_lsb(4'd5, 32'hFFFF);
        tick();
        idle_inputs();
        check("wake_not_yet", 32'(out_alu_enable), 32'd0);
        drive_alu(4'd2, 32'h10);
        tick();
        idle_inputs();
        check("wake_edge_enable", 32'(out_alu_enable), 32'd0);
        tick();
        check("wake_issue_enable", 32'(out_alu_enable), 32'd1);
        tick();

        // Fill all 16 slots pending on tag 1, then attempt an overflow dispatch.
        for (int i = 0; i < 16; i++) begin
            drive_dispatch(6'h03, 32'h2000 + 32'(4 * i), 32'(i), 4'(i), 1'b0, 32'h0, 4'd1,
                           1'b1, 32'h100 + 32'(i), 4'd0);
            sb.push_back('{typ:6'h03, pc:32'h2000 + 32'(4 * i), imm:32'(i), rs:32'h55,
                           rt:32'h100 + 32'(i), tag:4'(i)});
            tick();
            if (i == 14) check("fill_15_not_full", 32'(out_full), 32'd0);
        end
        idle_inputs();
        check("fill_full", 32'(out_full), 32'd1);
        drive_dispatch(6'h3F, 32'hBAD0, 32'h0, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick();
        idle_inputs();
        check("overflow_full", 32'(out_full), 32'd1);
        check("overflow_enable", 32'(out_alu_enable), 32'd0);
        drive_alu(4'd1, 32'h55);
        tick();
        idle_inputs();
        check("woken_still_full", 32'(out_full), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("drain_enable", 32'(out_alu_enable), 32'd1);
            if (k == 0) check("drain_full_drop", 32'(out_full), 32'd0);
        end
        tick();
        check("drain_done_enable", 32'(out_alu_enable), 32'd0);
        check("drain_empty", 32'(out_full), 32'd0);

        // Flush: four pending ops plus a same-cycle dispatch all disappear.
        for (int i = 0; i < 4; i++) begin
            drive_dispatch(6'h04, 32'h4000 + 32'(i), 32'h0, 4'(i), 1'b0, 32'h0, 4'd9, 1'b1, 32'h1, 4'd0);
            tick();
        end
        drive_dispatch(6'h04, 32'h4100, 32'h0, 4'd7, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        clear_in = 1'b1;
        tick();
        idle_inputs();
        check("clear_enable", 32'(out_alu_enable), 32'd0);
        check("clear_full", 32'(out_full), 32'd0);
        drive_alu(4'd9, 32'h77);
        tick();
        idle_inputs();
        tick();
        check("clear_no_issue_1", 32'(out_alu_enable), 32'd0);
        tick();
        check("clear_no_issue_2", 32'(out_alu_enable), 32'd0);

        // Stall: A issues, then rdy_in low for three edges holds B and the outputs.
        drive_dispatch(6'h06, 32'h5000, 32'h1, 4'd5, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0);
        sb.push_back('{typ:6'h06, pc:32'h5000, imm:32'h1, rs:32'hA1, rt:32'hA2, tag:4'd5});
        tick();
        drive_dispatch(6'h06, 32'h5004, 32'h2, 4'd6, 1'b1, 32'hB1, 4'd0, 1'b1, 32'hB2, 4'd0);
        sb.push_back('{typ:6'h06, pc:32'h5004, imm:32'h2, rs:32'hB1, rt:32'hB2, tag:4'd6});
        tick();
        idle_inputs();
        check("stall_a_enable", 32'(out_alu_enable), 32'd1);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_enable", 32'(out_alu_enable), 32'd0);
            check("stall_hold_reorder", 32'(out_alu_reorder), 32'd5);
        end
        rdy_in = 1'b1;
        tick();
        check("stall_b_enable", 32'(out_alu_enable), 32'd1);
        tick();
        check("stall_after_enable", 32'(out_alu_enable), 32'd0);

        // Reset mid-operation discards a pending entry and zeroes the outputs.
        drive_dispatch(6'h08, 32'h6000, 32'h0, 4'd3, 1'b0, 32'h0, 4'd12, 1'b1, 32'h3, 4'd0);
        tick();
        idle_inputs();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        check("midreset_full", 32'(out_full), 32'd0);
        check("midreset_rs", out_alu_rs, 32'd0);
        check("midreset_reorder", 32'(out_alu_reorder), 32'd0);
        drive_alu(4'd12, 32'h123);
        tick();
        idle_inputs();
        tick();
        check("midreset_no_issue", 32'(out_alu_enable), 32'd0);
        tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
